// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the divider.
// EX drives the operands and the start/annul controls. The divider drives
// back the packed {remainder, quotient} result and its ready flag.
interface div_if #(
    parameter int WIDTH = 32
);
    logic                 signed_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// The divider works on operand magnitudes and corrects the signs at the end.
// result_o = {remainder, quotient}, which feeds HI/LO.
// Timing of ready_o, counted from the edge that accepts start_i:
//   - nonzero divisor: ready_o rises on edge WIDTH+2.
//   - zero divisor: ready_o rises on edge 2, with result_o = 0.
// ready_o and result_o then hold until EX drops start_i.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,          // asynchronous, active low
    div_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_FREE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // During ON, dvd_q shifts left. It gives up one dividend bit at the top
    // each step and takes one quotient bit at the bottom, so it holds the
    // quotient once all the steps are done.
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    // The compare is done one bit wider than the operands. The partial
    // remainder can reach 2*divisor-1, which overflows WIDTH bits when the
    // divisor's MSB is set (e.g. DIVU by 0x80000000).
    logic [WIDTH:0]       partial;
    logic                 fits;
    logic [WIDTH:0]       diff;
    logic                 op1_neg, op2_neg;

    // Conditional two's-complement negate. It maps 0x80000000 to itself,
    // which gives the required wrap for the most negative dividend.
    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    // One restoring step: bring down the next dividend bit, then subtract if the divisor fits.
    always_comb begin
        partial = {rem_q, dvd_q[WIDTH-1]};
        fits    = (partial >= {1'b0, dvs_q});
        diff    = partial - {1'b0, dvs_q};
        op1_neg = bus.signed_i & bus.opdata1_i[WIDTH-1];
        op2_neg = bus.signed_i & bus.opdata2_i[WIDTH-1];
    end

    // Next-state and next-datapath logic for the FREE/BYZERO/ON/END sequencer.
    always_comb begin
        // NOTE: every target gets a hold value first; a branch that forgets one would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                // annul_i wins over start_i, so a flushed request is never accepted.
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        dvd_d   = neg_if(op1_neg, bus.opdata1_i);
                        dvs_d   = neg_if(op2_neg, bus.opdata2_i);
                        rem_d   = '0;
                        qneg_d  = op1_neg ^ op2_neg;
                        rneg_d  = op1_neg;
                    end
                end
            end

            S_BYZERO: begin
                // Divide by zero is architecturally undefined on MIPS. Return zero and raise no trap.
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = S_END;
            end

            S_ON: begin
                if (bus.annul_i) begin
                    // A flush abandons the operation silently; nothing reaches HI/LO.
                    state_d = S_FREE;
                    cnt_d   = '0;
                    dvd_d   = '0;
                    dvs_d   = '0;
                    rem_d   = '0;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                end else if (cnt_q == CW'(WIDTH)) begin
                    result_d = {neg_if(rneg_q, rem_q), neg_if(qneg_q, dvd_q)};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end else begin
                    rem_d = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_END: begin
                // Hold the result while EX keeps start_i high, because the pipeline
                // may still be stalled. A flush here acts like EX releasing start_i.
                if (!bus.start_i || bus.annul_i) begin
                    state_d  = S_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = S_FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // State, work and output registers; reset clears them all, outputs included, without a clock.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the work registers are cleared on reset as well, so the first result after
        // reset never depends on power-up values even though FREE reloads them on start.
        if (!rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values,
            // the same way the hardware flops do.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (WIDTH=32).
// The vectors cover: unsigned and signed division, the most-negative wrap,
// divide by zero, annul during ON and in FREE, async reset in ON and in END,
// and holding the result in END.
// Expected values are worked out by hand from the division definitions.
module tb_div_unit;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for ready_o. Then check how many edges it took since the start
    // edge (already_done edges have passed before the call) and check the result.
    task automatic wait_ready(input string tag, input int already_done, input int exp_edges,
                              input logic [63:0] exp);
        int n;
        n = already_done;
        while (n < 60) begin
            tick();
            n++;
            if (bus.ready_o === 1'b1) break;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_edges));
        check({tag, " result"}, bus.result_o, exp);
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_edges);
        bus.signed_i  = sg;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.start_i   = 1'b1;
        wait_ready(tag, 0, exp_edges, exp);
    endtask

    // Release start_i; the divider must clear its outputs on the next edge.
    task automatic end_op(input string tag);
        bus.start_i = 1'b0;
        tick();
        check({tag, " release ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, " release result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        n_checks = 0;
        n_fails  = 0;

        bus.signed_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.start_i   = 1'b0;
        bus.annul_i   = 1'b0;
        rst           = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        repeat (2) tick();
        #4 rst = 1'b1;
        tick();
        check("idle ready", 64'(bus.ready_o), 64'd0);

        // 44 / 3 = 14 rem 2
        run_op("divu 44/3", 1'b0, 32'h0000002C, 32'h00000003, 64'h00000002_0000000E, 34);
        end_op("divu 44/3");

        // -7 / 2 = -3 rem -1 (the remainder takes the dividend's sign)
        run_op("div -7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34);
        end_op("div -7/2");

        // 4294967289 / 2 = 2147483644 rem 1
        run_op("divu fff9/2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 34);
        end_op("divu fff9/2");

        // Most negative / -1 wraps to itself with no flag
        run_op("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        end_op("div min/-1");

        // Divide by zero: ready on edge 2, zero result
        run_op("divu 5/0", 1'b0, 32'h00000005, 32'h00000000, 64'h0, 2);
        end_op("divu 5/0");

        // Dividend smaller than divisor
        run_op("divu 3/10", 1'b0, 32'h00000003, 32'h0000000A, 64'h00000003_00000000, 34);
        end_op("divu 3/10");

        // Divisor with MSB set needs the wide compare: 0xFFFFFFFF / 0x80000000 = 1 rem 0x7FFFFFFF
        run_op("divu max/msb", 1'b0, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001, 34);
        end_op("divu max/msb");

        // 7 / -2 = -3 rem 1
        run_op("div 7/-2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        end_op("div 7/-2");

        // Operands changed during ON must be ignored: 100 / 7 = 14 rem 2
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        repeat (5) tick();
        bus.opdata1_i = 32'h0000FFFF;
        bus.opdata2_i = 32'h00000001;
        bus.signed_i  = 1'b1;
        wait_ready("operand change", 5, 34, 64'h00000002_0000000E);
        end_op("operand change");

        // start_i and annul_i together in FREE: annul wins
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        repeat (3) tick();
        check("start+annul free ready", 64'(bus.ready_o), 64'd0);
        bus.annul_i = 1'b0;
        wait_ready("after start+annul", 0, 34, 64'h00000002_0000000E);
        end_op("after start+annul");

        // annul pulsed at edge 10 of ON, then a new start on the next cycle
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'h0000002C;
        bus.opdata2_i = 32'h00000003;
        bus.start_i   = 1'b1;
        repeat (9) tick();
        bus.annul_i = 1'b1;
        tick();
        check("annul ready", 64'(bus.ready_o), 64'd0);
        check("annul result", bus.result_o, 64'd0);
        bus.annul_i = 1'b0;
        run_op("after annul 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        end_op("after annul 100/7");

        // Async reset at edge 20 of ON
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        repeat (20) tick();
        bus.start_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst in ON ready", 64'(bus.ready_o), 64'd0);
        check("rst in ON result", bus.result_o, 64'd0);
        #2 rst = 1'b1;
        tick();

        // Async reset in END must clear the outputs before any clock edge
        run_op("pre-rst op", 1'b0, 32'h0000002C, 32'h00000003, 64'h00000002_0000000E, 34);
        #2 rst = 1'b0;
        #1;
        check("rst in END ready", 64'(bus.ready_o), 64'd0);
        check("rst in END result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        #2 rst = 1'b1;
        tick();
        run_op("post-rst 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        end_op("post-rst 100/7");

        // Hold start_i in END for 5 extra cycles, release, then re-run the same operands
        run_op("hold op", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34);
        held = 64'hFFFFFFFF_FFFFFFFD;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold ready", 64'(bus.ready_o), 64'd1);
            check("hold result", bus.result_o, held);
        end
        end_op("hold op");
        run_op("repeat op", 1'b1, 32'hFFFFFFF9, 32'h00000002, held, 34);
        end_op("repeat op");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
